// File: rtl/top_level.sv
// Button-driven 16-bit stack/queue calculator.
// Each button is synchronized and debounced and then edge-detected into a
// one-cycle command. The commands are push, pop and the arithmetic ops
// add, subtract and multiply. Storage is a circular register array. The
// live entries always run from rd_ptr (oldest) to wr_ptr-1 (newest).
// Queue mode reads at rd_ptr and stack mode reads at wr_ptr-1, so flipping
// the mode never moves any data.
module top_level #(
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stackQueue,
  input  logic [15:0] switches,
  input  logic [4:0]  btns,
  output logic        empty,
  output logic        full
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, READ_A, READ_B, WRITE} state_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_e;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
  endfunction

  logic [4:0]     sync1, sync2, deb, deb_prev, pulse;
  logic [DBW-1:0] db_cnt [5];

  logic [15:0]    mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr, rd_addr;
  logic [CW-1:0]  count;

  state_e         state, next_state;
  op_e            op, new_op;
  logic           op_mode, rd_mode;
  logic           do_push, do_pop, start_op;
  logic [15:0]    a_reg, b_reg, rd_data, wr_data, result;

  // Two-flop synchronizer for the asynchronous button inputs.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btns;
      sync2 <= sync1;
    end
  end

  // Per-button debouncer: flip the output after DEBOUNCE_CYCLES consecutive
  // samples at the new level, and remember the last level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb      <= '0;
      deb_prev <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      deb_prev <= deb;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign pulse = deb & ~deb_prev;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Command arbitration, FSM next state and datapath controls.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    start_op   = 1'b0;
    new_op     = OP_ADD;
    wr_data    = switches;
    rd_mode    = stackQueue;
    case (state)
      IDLE: begin
        // The lowest button index wins, and a winner that cannot run still
        // swallows the other pulses.
        if (pulse[0]) begin
          do_push = (count != CW'(DEPTH));
        end else if (pulse[1]) begin
          do_pop = (count != '0);
        end else if (|pulse[4:2] && count >= CW'(2)) begin
          start_op   = 1'b1;
          next_state = READ_A;
          new_op     = pulse[2] ? OP_ADD : (pulse[3] ? OP_SUB : OP_MUL);
        end
      end
      READ_A: begin
        rd_mode    = op_mode;
        do_pop     = 1'b1;
        next_state = READ_B;
      end
      READ_B: begin
        rd_mode    = op_mode;
        do_pop     = 1'b1;
        next_state = WRITE;
      end
      WRITE: begin
        do_push    = 1'b1;
        wr_data    = result;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Read-end selection and the arithmetic result (B op A, modulo 2^16).
  always_comb begin
    rd_addr = rd_mode ? rd_ptr : ptr_dec(wr_ptr);
    rd_data = mem[rd_addr];
    case (op)
      OP_ADD:  result = b_reg + a_reg;
      OP_SUB:  result = b_reg - a_reg;
      default: result = b_reg * a_reg;
    endcase
  end

  // Pointers, count, operand capture and registered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      op      <= OP_ADD;
      op_mode <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
    end else begin
      if (start_op) begin
        op      <= new_op;
        op_mode <= stackQueue;
      end
      if (state == READ_A) a_reg <= rd_data;
      if (state == READ_B) b_reg <= rd_data;
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
        count  <= count + 1'b1;
      end else if (do_pop) begin
        if (rd_mode) rd_ptr <= ptr_inc(rd_ptr);
        else         wr_ptr <= ptr_dec(wr_ptr);
        count <= count - 1'b1;
      end
      empty <= (count == '0);
      full  <= (count == CW'(DEPTH));
    end
  end

  // Storage array write port.
  // NOTE: the array is deliberately left out of reset; the pointers and the
  // count define which entries are valid, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level. It runs with a short debounce interval.
// A queue model holds the entries oldest-first and is compared against the
// DUT's live entries, count and flags.
module tb_top_level;

  localparam int DEPTH = 8;
  localparam int DB    = 4;
  localparam int HOLD  = DB + 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stackQueue = 1'b0;
  logic [15:0] switches = '0;
  logic [4:0]  btns = '0;
  logic        empty, full;

  int checks = 0;
  int errors = 0;
  logic [15:0] model [$];

  top_level #(.DEPTH(DEPTH), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .stackQueue(stackQueue), .switches(switches),
    .btns(btns), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mode;
    logic [15:0] sw;
    logic [4:0]  btn;
    int          exp_count;
    bit          exp_empty;
    bit          exp_full;
    logic [15:0] exp_top;
  } vec_t;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour of one accepted command, from the storage rules.
  function automatic logic [15:0] take(input bit mode);
    logic [15:0] v;
    if (mode) v = model.pop_front();
    else      v = model.pop_back();
    return v;
  endfunction

  task automatic model_apply(input bit mode, input logic [15:0] sw, input int idx);
    logic [15:0] a, b;
    case (idx)
      0: if (model.size() < DEPTH) model.push_back(sw);
      1: if (model.size() > 0) a = take(mode);
      default: if (model.size() >= 2) begin
        a = take(mode);
        b = take(mode);
        case (idx)
          2: model.push_back(b + a);
          3: model.push_back(b - a);
          default: model.push_back(16'((32'(b) * 32'(a)) % 65536));
        endcase
      end
    endcase
  endtask

  task automatic check_state(input string tag);
    check({tag, " count"}, 32'(dut.count), 32'(model.size()));
    check({tag, " empty"}, 32'(empty), 32'(model.size() == 0));
    check({tag, " full"}, 32'(full), 32'(model.size() == DEPTH));
    for (int i = 0; i < model.size(); i++)
      check($sformatf("%s entry%0d", tag, i),
            32'(dut.mem[(int'(dut.rd_ptr) + i) % DEPTH]), 32'(model[i]));
  endtask

  task automatic press(input bit mode, input logic [15:0] sw, input logic [4:0] mask);
    stackQueue = mode;
    switches   = sw;
    btns       = mask;
    tick(HOLD);
    btns = '0;
    tick(HOLD);
  endtask

  function automatic int first_idx(input logic [4:0] mask);
    for (int i = 0; i < 5; i++) if (mask[i]) return i;
    return 0;
  endfunction

  vec_t vecs [25];
  int   waited;

  initial begin
    // Directed table: push/pop basics, stack and queue arithmetic, fill.
    vecs[0]  = '{0, 16'hF0F0, 5'b00001, 1, 0, 0, 16'hF0F0};
    vecs[1]  = '{0, 16'h0000, 5'b00010, 0, 1, 0, 16'h0000};
    vecs[2]  = '{0, 16'h0000, 5'b00010, 0, 1, 0, 16'h0000};
    vecs[3]  = '{0, 16'h0005, 5'b00001, 1, 0, 0, 16'h0005};
    vecs[4]  = '{0, 16'h0003, 5'b00001, 2, 0, 0, 16'h0003};
    vecs[5]  = '{0, 16'h0000, 5'b01000, 1, 0, 0, 16'h0002};
    vecs[6]  = '{0, 16'hFFFF, 5'b00001, 2, 0, 0, 16'hFFFF};
    vecs[7]  = '{0, 16'h0000, 5'b00100, 1, 0, 0, 16'h0001};
    vecs[8]  = '{0, 16'h0000, 5'b00010, 0, 1, 0, 16'h0000};
    vecs[9]  = '{1, 16'h0001, 5'b00001, 1, 0, 0, 16'h0001};
    vecs[10] = '{1, 16'h0002, 5'b00001, 2, 0, 0, 16'h0001};
    vecs[11] = '{1, 16'h0003, 5'b00001, 3, 0, 0, 16'h0001};
    vecs[12] = '{1, 16'h0000, 5'b00010, 2, 0, 0, 16'h0002};
    vecs[13] = '{1, 16'h0000, 5'b10000, 1, 0, 0, 16'h0006};
    vecs[14] = '{1, 16'h0000, 5'b00010, 0, 1, 0, 16'h0000};
    for (int i = 0; i < 8; i++)
      vecs[15 + i] = '{0, 16'(16'h10 + i), 5'b00001, i + 1, 0, (i == 7), 16'(16'h10 + i)};
    vecs[23] = '{0, 16'h0099, 5'b00001, 8, 0, 1, 16'h0017};
    vecs[24] = '{0, 16'h0000, 5'b00010, 7, 0, 0, 16'h0016};

    // Reset state.
    tick(3);
    check("reset empty", 32'(empty), 32'd1);
    check("reset full", 32'(full), 32'd0);
    check("reset count", 32'(dut.count), 32'd0);
    rst = 1'b0;
    tick(2);

    foreach (vecs[i]) begin
      press(vecs[i].mode, vecs[i].sw, vecs[i].btn);
      model_apply(vecs[i].mode, vecs[i].sw, first_idx(vecs[i].btn));
      check($sformatf("vec%0d count", i), 32'(dut.count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].exp_full));
      if (vecs[i].exp_count > 0)
        check($sformatf("vec%0d top", i),
              32'(vecs[i].mode ? dut.mem[dut.rd_ptr]
                               : dut.mem[(int'(dut.rd_ptr) + vecs[i].exp_count - 1) % DEPTH]),
              32'(vecs[i].exp_top));
      check_state($sformatf("vec%0d", i));
    end

    // A bounce shorter than the debounce interval is no command.
    stackQueue = 1'b0;
    repeat (3) begin
      btns = 5'b00010;
      tick(DB - 1);
      btns = '0;
      tick(DB);
    end
    tick(HOLD);
    check_state("bounce");

    // Simultaneous pop and add: pop has priority, add is dropped.
    press(0, 16'h0000, 5'b00110);
    model_apply(0, 16'h0000, 1);
    check_state("priority");

    // A push arriving one cycle after add lands while the FSM is busy.
    btns = 5'b00100;
    tick(1);
    btns = 5'b00101;
    tick(HOLD);
    btns = '0;
    tick(HOLD);
    model_apply(0, 16'h0000, 2);
    check_state("busy drop");

    // Reset in the middle of a subtract aborts it and empties storage.
    btns = 5'b01000;
    waited = 0;
    while (int'(dut.state) == 0 && waited < 100) begin
      tick(1);
      waited++;
    end
    check("arith start timeout", 32'(waited < 100), 32'd1);
    rst = 1'b1;
    btns = '0;
    #1;
    check("midop count", 32'(dut.count), 32'd0);
    check("midop empty", 32'(empty), 32'd1);
    check("midop full", 32'(full), 32'd0);
    check("midop state", 32'(int'(dut.state)), 32'd0);
    model.delete();
    tick(3);

    // A button held through reset is accepted once, after a full interval.
    switches = 16'hABCD;
    btns = 5'b00001;
    tick(2);
    rst = 1'b0;
    tick(2);
    check("held early count", 32'(dut.count), 32'd0);
    tick(DB + 8);
    check("held accept count", 32'(dut.count), 32'd1);
    tick(3 * DB);
    btns = '0;
    tick(HOLD);
    model_apply(0, 16'hABCD, 0);
    check_state("held");

    // Randomized commands against the model.
    for (int n = 0; n < 80; n++) begin
      bit          mode;
      logic [15:0] sw;
      int          idx;
      mode = 1'($urandom_range(1));
      sw   = 16'($urandom);
      idx  = $urandom_range(6);
      if (idx > 4) idx = 0;
      press(mode, sw, 5'(1 << idx));
      model_apply(mode, sw, idx);
      check_state($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
